// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache for the fetch port.
// Hits answer combinationally in the same cycle. A miss stalls fetch while
// a full line is read from physical memory into the selected set.
// Also provides invalidate-all and saturating hit/miss counters.
module icache_direct #(
  parameter int S_INDEX  = 3,
  parameter int S_OFFSET = 5,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_read,
  input  logic [31:0]               mem_address,
  output logic [31:0]               mem_rdata,
  output logic                      mem_resp,
  input  logic                      invalidate,
  output logic                      pmem_read,
  output logic [31:0]               pmem_address,
  input  logic [(8<<S_OFFSET)-1:0]  pmem_rdata,
  input  logic                      pmem_resp,
  output logic [CNT_W-1:0]          hit_count,
  output logic [CNT_W-1:0]          miss_count
);

  localparam int S_TAG  = 32 - S_INDEX - S_OFFSET;
  localparam int SETS   = 1 << S_INDEX;
  localparam int LINE_W = 8 << S_OFFSET;
  localparam int WORD_W = S_OFFSET - 2;
  localparam int LADR_W = 32 - S_OFFSET;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [SETS-1:0]    valid_reg;
  logic [SETS-1:0]    valid_next;
  logic [S_TAG-1:0]   tag_reg  [SETS];
  logic [LINE_W-1:0]  data_reg [SETS];

  // Line address ({tag, index}) of the miss currently being serviced.
  logic [LADR_W-1:0]  miss_line_reg;
  // Set when invalidate arrives while the line is in flight, so the fill
  // lands with its valid bit clear.
  logic               inv_seen_reg;

  logic [CNT_W-1:0]   hit_count_reg;
  logic [CNT_W-1:0]   miss_count_reg;

  logic [S_TAG-1:0]   req_tag;
  logic [S_INDEX-1:0] req_index;
  logic [WORD_W-1:0]  req_word;
  logic [S_INDEX-1:0] miss_index;
  logic [S_TAG-1:0]   miss_tag;
  logic [LINE_W-1:0]  line_sel;
  logic               hit;
  logic               miss;
  logic               fill_en;

  // Byte-within-word bits never select anything in an instruction cache.
  logic               unused_addr_bits;
  assign unused_addr_bits = ^mem_address[1:0];

  assign req_tag    = mem_address[31 -: S_TAG];
  assign req_index  = mem_address[S_OFFSET +: S_INDEX];
  assign req_word   = mem_address[2 +: WORD_W];
  assign miss_index = miss_line_reg[S_INDEX-1:0];
  assign miss_tag   = miss_line_reg[LADR_W-1 -: S_TAG];
  assign line_sel   = data_reg[req_index];

  // Invalidate wins over a hit in the same cycle so fence.i can never be
  // followed by a stale instruction.
  assign hit  = (state_reg == IDLE) && mem_read && !invalidate &&
                valid_reg[req_index] && (tag_reg[req_index] == req_tag);
  assign miss = (state_reg == IDLE) && mem_read && !hit;

  assign mem_resp  = hit;
  assign mem_rdata = hit ? line_sel[{req_word, 5'b00000} +: 32] : 32'd0;

  assign pmem_address = pmem_read ? {miss_line_reg, {S_OFFSET{1'b0}}} : 32'd0;
  assign hit_count    = hit_count_reg;
  assign miss_count   = miss_count_reg;

  // State register; reset abandons any in-flight line read.
  always_ff @(posedge clk) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic and memory-side request generation.
  always_comb begin
    state_next = state_reg;
    pmem_read  = 1'b0;
    fill_en    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (miss) state_next = FETCH;
      end
      FETCH: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          fill_en    = 1'b1;
          state_next = FILL;
        end
      end
      FILL: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Per-set valid update: invalidate clears everything, a fill sets only
  // its own set unless an invalidate was seen during the fetch.
  genvar gi;
  generate
    for (gi = 0; gi < SETS; gi++) begin : g_valid
      assign valid_next[gi] = invalidate ? 1'b0 :
                              (fill_en && (miss_index == S_INDEX'(gi))) ? !inv_seen_reg :
                              valid_reg[gi];
    end
  endgenerate

  // Valid bits are the only reset part of the storage.
  always_ff @(posedge clk) begin
    if (!rst) valid_reg <= '0;
    else      valid_reg <= valid_next;
  end

  // Tag and data arrays take the returned line on completion of a fetch.
  always_ff @(posedge clk) begin
    if (rst && fill_en) begin
      tag_reg[miss_index]  <= miss_tag;
      data_reg[miss_index] <= pmem_rdata;
    end
  end

  // Capture the line address at miss time so the request stays stable even
  // if the fetch address wanders during the fetch.
  always_ff @(posedge clk) begin
    if (!rst)      miss_line_reg <= '0;
    else if (miss) miss_line_reg <= mem_address[31:S_OFFSET];
  end

  // Remember an invalidate that lands while a line is in flight.
  always_ff @(posedge clk) begin
    if (!rst)                                      inv_seen_reg <= 1'b0;
    else if (miss)                                 inv_seen_reg <= 1'b0;
    else if ((state_reg == FETCH) && invalidate)   inv_seen_reg <= 1'b1;
  end

  // Saturating performance counters; a miss counts once when it is detected.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      if (hit && (hit_count_reg != {CNT_W{1'b1}}))
        hit_count_reg <= hit_count_reg + CNT_W'(1);
      if (miss && (miss_count_reg != {CNT_W{1'b1}}))
        miss_count_reg <= miss_count_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: a scoreboard queue holds the word
// each fetch must return, a small memory model answers line reads after a
// fixed latency, and directed sequences cover hits, misses, conflicts,
// invalidation, reset during a fetch and counter saturation.
module tb_icache_direct;

  localparam int CNT_W = 4;
  localparam int LAT   = 3;

  logic              clk;
  logic              rst;
  logic              mem_read;
  logic [31:0]       mem_address;
  logic [31:0]       mem_rdata;
  logic              mem_resp;
  logic              invalidate;
  logic              pmem_read;
  logic [31:0]       pmem_address;
  logic [255:0]      pmem_rdata;
  logic              pmem_resp;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  logic              model_resp;
  logic [255:0]      model_line;
  logic              force_resp;
  logic [255:0]      force_line;
  int                lat_cnt;

  int                n_total;
  int                n_pass;
  logic [31:0]       exp_q[$];

  assign pmem_resp  = model_resp | force_resp;
  assign pmem_rdata = force_resp ? force_line : model_line;

  icache_direct #(.S_INDEX(3), .S_OFFSET(5), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .invalidate   (invalidate),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  always #5 clk = ~clk;

  // Word k of a line: 0x1000_0000 + (tag << 16) + ((index ^ 3) << 8) + k,
  // so line 0x60 holds 0x1000_0000 + k.
  function automatic logic [31:0] model_word(input logic [31:0] a);
    return 32'h1000_0000 + ({16'h0, a[23:8]} << 16) +
           ({29'h0, a[7:5] ^ 3'd3} << 8) + {29'h0, a[4:2]};
  endfunction

  function automatic logic [255:0] make_line(input logic [31:0] a);
    logic [255:0] l;
    logic [2:0]   kk;
    l = '0;
    for (int k = 0; k < 8; k++) begin
      kk = 3'(k);
      l[32*k +: 32] = model_word({a[31:5], kk, 2'b00});
    end
    return l;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp)
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // Memory model: answers a held line read on its LAT-th cycle.
  always @(negedge clk) begin
    if (pmem_read) begin
      lat_cnt = lat_cnt + 1;
      if (lat_cnt == LAT) begin
        model_resp = 1'b1;
        model_line = make_line(pmem_address);
      end else begin
        model_resp = 1'b0;
      end
    end else begin
      lat_cnt    = 0;
      model_resp = 1'b0;
    end
  end

  // Issue one fetch and hold it until mem_resp. Expected word is queued at
  // issue and popped when the cache answers. Line-read starts are counted
  // and pmem_address is checked every cycle a read is pending.
  // inv_cycle >= 0 pulses invalidate during that cycle of the request.
  task automatic do_fetch(input logic [31:0] addr, input int exp_rises,
                          input int inv_cycle, output int cyc);
    logic [31:0] exp_d;
    int          rises;
    logic        prev;
    bit          done;
    exp_q.push_back(model_word(addr));
    mem_read    = 1'b1;
    mem_address = addr;
    cyc   = 0;
    rises = 0;
    prev  = 1'b0;
    done  = 1'b0;
    while (!done && cyc < 40) begin
      invalidate = (cyc == inv_cycle);
      #1;
      if (pmem_read && !prev) rises++;
      prev = pmem_read;
      if (pmem_read) check("pmem_addr", pmem_address, {addr[31:5], 5'b00000});
      if (mem_resp) begin
        exp_d = exp_q.pop_front();
        check("rdata", mem_rdata, exp_d);
        done = 1'b1;
      end
      @(negedge clk);
      if (!done) cyc++;
    end
    invalidate = 1'b0;
    check("fetch_done", 32'(done), 32'd1);
    if (!done) exp_q.delete();
    check("pmem_reads", 32'(rises), 32'(exp_rises));
    $display("fetch addr=%h data=%h line_reads=%0d stall_cycles=%0d", addr, mem_rdata, rises, cyc);
  endtask

  task automatic reset_dut();
    mem_read   = 1'b0;
    invalidate = 1'b0;
    rst        = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int cyc;
    clk = 0; rst = 0; mem_read = 0; mem_address = 0; invalidate = 0;
    force_resp = 0; force_line = '0; model_resp = 0; model_line = '0; lat_cnt = 0;
    n_total = 0; n_pass = 0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_resp",  32'(mem_resp), 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_pread", 32'(pmem_read), 32'd0);
    check("rst_paddr", pmem_address, 32'd0);
    check("rst_hits",  32'(hit_count), 32'd0);
    check("rst_miss",  32'(miss_count), 32'd0);
    rst = 1;
    @(negedge clk);

    // 1. Cold miss on 0x64 then the retried hit
    do_fetch(32'h0000_0064, 1, -1, cyc);
    mem_read = 0;
    #1;
    check("t1_miss", 32'(miss_count), 32'd1);
    check("t1_hits", 32'(hit_count), 32'd1);

    // 2. Same-line hits back to back
    do_fetch(32'h0000_0060, 0, -1, cyc);
    check("t2_lat0", 32'(cyc), 32'd0);
    do_fetch(32'h0000_007C, 0, -1, cyc);
    check("t2_lat1", 32'(cyc), 32'd0);
    mem_read = 0;
    #1;
    check("t2_hits", 32'(hit_count), 32'd3);
    check("t2_miss", 32'(miss_count), 32'd1);

    // 3. Conflict eviction in set 3
    reset_dut();
    do_fetch(32'h0000_0060, 1, -1, cyc);
    do_fetch(32'h0000_0160, 1, -1, cyc);
    do_fetch(32'h0000_0060, 1, -1, cyc);
    mem_read = 0;
    #1;
    check("t3_miss", 32'(miss_count), 32'd3);
    check("t3_hits", 32'(hit_count), 32'd3);

    // 4a. Invalidate pulse, then re-read misses
    reset_dut();
    do_fetch(32'h0000_0060, 1, -1, cyc);
    mem_read = 0;
    invalidate = 1;
    @(negedge clk);
    invalidate = 0;
    do_fetch(32'h0000_0060, 1, -1, cyc);
    // Invalidate beats a would-be hit in the same cycle
    mem_read = 1; mem_address = 32'h0000_0060; invalidate = 1;
    #1;
    check("t4_prio_resp", 32'(mem_resp), 32'd0);
    @(negedge clk);
    invalidate = 0; mem_read = 0;
    #1;
    check("t4_prio_hits", 32'(hit_count), 32'd2);
    repeat (10) @(negedge clk);
    // 4b. Invalidate in the first fetch cycle: fill lands invalid, so the
    // retry must read the line a second time
    do_fetch(32'h0000_0160, 2, 1, cyc);
    mem_read = 0;

    // 5. Reset in the second fetch cycle, then a late pmem_resp
    reset_dut();
    @(negedge clk);
    mem_read = 1; mem_address = 32'h0000_0060;
    #1;
    check("t5_first_resp", 32'(mem_resp), 32'd0);
    @(negedge clk);
    #1;
    check("t5_fetch", 32'(pmem_read), 32'd1);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    #1;
    check("t5_pread_off", 32'(pmem_read), 32'd0);
    check("t5_paddr_off", pmem_address, 32'd0);
    rst = 1; mem_read = 0;
    force_line = make_line(32'h0000_0060);
    force_resp = 1;
    @(negedge clk);
    force_resp = 0;
    #1;
    check("t5_hits", 32'(hit_count), 32'd0);
    check("t5_miss", 32'(miss_count), 32'd0);
    check("t5_pread", 32'(pmem_read), 32'd0);
    do_fetch(32'h0000_0060, 1, -1, cyc);
    mem_read = 0;

    // 6. Hit counter saturation at 2^CNT_W-1
    reset_dut();
    do_fetch(32'h0000_0060, 1, -1, cyc);
    for (int i = 0; i < 19; i++) begin
      do_fetch(32'h0000_0060 + 32'(4 * (i % 8)), 0, -1, cyc);
    end
    mem_read = 0;
    #1;
    check("t6_sat", 32'(hit_count), 32'd15);
    check("t6_miss", 32'(miss_count), 32'd1);
    do_fetch(32'h0000_0068, 0, -1, cyc);
    mem_read = 0;
    #1;
    check("t6_hold", 32'(hit_count), 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the pipeline fetch port (inst_mem_read / inst_mem_address / inst_mem_rdata / inst_mem_resp) and the physical memory line interface.
- Replaces the single-cycle magic instruction memory.
- Hits return in the same cycle. Misses stall fetch via mem_resp=0 while a full 256-bit line is fetched from pmem.
- Also provides invalidate-all (for fence.i) and saturating hit/miss counters for performance analysis.

Parameters:
S_INDEX, 3, index bits; number of sets = 2^S_INDEX = 8
S_OFFSET, 5, byte-offset bits; line = 32 bytes = 256 bits = 8 words
S_TAG, 32-S_INDEX-S_OFFSET = 24, tag bits (derived, not overridable)
CNT_W, 16, width of hit/miss counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-low (rst==0 resets)
mem_read  in  1  fetch request from datapath
mem_address  in  32  byte address; bits [1:0] ignored
mem_rdata  out  32  instruction word
mem_resp  out  1  request satisfied this cycle
invalidate  in  1  clear all valid bits (fence.i)
pmem_read  out  1  line read request to memory
pmem_address  out  32  line-aligned address; low S_OFFSET bits = 0
pmem_rdata  in  256  returned line
pmem_resp  in  1  line valid this cycle
hit_count  out  CNT_W  saturating hit counter
miss_count  out  CNT_W  saturating miss counter

Behaviour:
- Address fields: tag = addr[31:8], index = addr[7:5], word = addr[4:2].
- Storage per set: valid bit, tag, 256-bit data line. Storage is flops.
- Valid bits reset to 0. Tag and data arrays are not reset.
- Hit = mem_read & valid[index] & (tag_array[index]==tag), in state IDLE.
- On a hit, in the same cycle and combinationally:
  - mem_resp=1.
  - mem_rdata = line[index][32*word +: 32].
  - Zero-cycle latency, matching magic-memory timing expected by the hazard unit.
- Outside a hit: mem_resp=0 and mem_rdata=0.
- FSM states: IDLE, FETCH, FILL.
  - IDLE, hit: stay in IDLE; hit_count++.
  - IDLE, mem_read & !hit: latch miss_addr = {mem_address[31:5], 5'b0}; go to FETCH; miss_count++ (once per miss).
  - FETCH: pmem_read=1 and pmem_address=miss_addr, held stable until pmem_resp. On pmem_resp: write pmem_rdata to data[miss index], write miss tag, set valid; go to FILL.
  - FILL: one cycle; pmem_read=0; mem_resp=0; return to IDLE. The retried request then hits, so miss latency = pmem latency + 2 cycles.
- pmem_read is 0 in IDLE and FILL. pmem_address is 0 whenever pmem_read=0.
- The datapath holds mem_address stable while mem_resp=0. If mem_address changes during FETCH anyway, the in-flight line is still filled for miss_addr; the new address is evaluated in IDLE.
- mem_read=0 in IDLE: no state change, no counter change.
- invalidate=1:
  - Clears all valid bits at the next edge, in any state.
  - If asserted in FETCH, the fetch completes but the filled line is written with valid=0.
  - In IDLE, invalidate takes priority over a hit that cycle: mem_resp=0 and no hit_count increment. The request then misses.
- pmem_resp in IDLE or FILL is ignored.
- Counters saturate at 2^CNT_W-1; no wrap.
- Reset (rst==0) at any edge, including mid-FETCH:
  - State returns to IDLE; pmem_read=0 at the following cycle.
  - All valid bits clear; counters clear; miss_addr is cleared to 0.
  - A pmem_resp arriving after reset is ignored.
- Reset outputs: mem_resp=0, mem_rdata=0, pmem_read=0, pmem_address=0, hit_count=0, miss_count=0.

Test Plan:
1. Cold miss:
   - Stimulus: after reset, mem_read=1, addr=0x00000064; pmem returns line with word k = 0x1000_0000+k after 3 cycles.
   - Required: pmem_address=0x00000060 held until pmem_resp; then FILL; next cycle mem_resp=1, mem_rdata=0x10000001; miss_count=1, hit_count=1.
2. Same-line hits:
   - Stimulus: addresses 0x60, 0x7C back-to-back.
   - Required: mem_resp=1 each cycle; data 0x10000000, 0x10000007; no pmem_read.
3. Conflict eviction:
   - Stimulus: fetch 0x00000060, then 0x00000160 (same index 3, different tag), then 0x00000060 again.
   - Required: three misses; each pmem_address is the respective line base.
4. Invalidate:
   - Stimulus: warm line 0x60; pulse invalidate; re-read 0x60.
   - Required: miss with pmem_read=1.
   - Stimulus: invalidate during FETCH.
   - Required: the line is not valid afterwards.
5. Reset mid-miss:
   - Stimulus: drive rst=0 in the second FETCH cycle; late pmem_resp arrives.
   - Required: pmem_read=0 next cycle; late pmem_resp ignored; counters 0; subsequent read misses.
6. Saturation:
   - Stimulus: CNT_W=4; 20 hits.
   - Required: hit_count=15, stays at 15.
